// File: rtl/seq_arith_pkg.sv
// ---------------------------------------------------------------------------
// seq_arith_pkg
// Shared types for the iterative multiply / divide / modular-multiply engine.
//   op_e    : operation code presented on the engine's mode input
//   state_e : control FSM states of seq_arith_unit
// ---------------------------------------------------------------------------
package seq_arith_pkg;

    // Operand width used when the engine is instantiated without an override.
    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_DIV    = 2'b01,
        OP_MODMUL = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

endpackage

// File: rtl/seq_arith_step.sv
// ---------------------------------------------------------------------------
// seq_arith_step
// Purely combinational single iteration of the sequential arithmetic engine.
// One instance is shared by all operations; the top feeds back its outputs
// into its working registers once per clock.
// Ports:
//   mode_i : operation being executed (captured by the top at start)
//   acc_i  : working accumulator (MUL high half, DIV remainder, MODMUL acc)
//   lo_i   : working low word (MUL multiplier/product low, DIV dividend/
//            quotient, MODMUL multiplier shifted MSB-first)
//   a_i    : captured operand A
//   b_i    : captured operand B (DIV divisor)
//   m_i    : captured modulus
//   acc_o  : accumulator after this iteration
//   lo_o   : low word after this iteration
// ---------------------------------------------------------------------------
module seq_arith_step
    import seq_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  op_e              mode_i,
    input  logic [WIDTH+1:0] acc_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH+1:0] acc_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic [WIDTH:0]   divDiff;
    logic             divFits;
    logic [WIDTH+1:0] modM;
    logic [WIDTH+1:0] modT;
    logic [WIDTH+1:0] modT1;
    logic [WIDTH+1:0] modT2;

    // All three iteration flavours are computed in parallel and the captured
    // mode picks which one is written back.
    //  - MUL: add A into the high half when the current multiplier LSB is set,
    //    then shift the whole {carry, high, low} product right by one. The bit
    //    falling out of the high half becomes the next product low bit while
    //    the consumed multiplier bit drops off the bottom of the low word.
    //  - DIV: shift the next dividend bit into the remainder and subtract the
    //    divisor only if it fits (restoring division); the outcome is the next
    //    quotient bit, shifted into the low word.
    //  - MODMUL: double the accumulator and add A for the current multiplier
    //    bit. Since acc < m and a < m going in, the sum is below 3m, so two
    //    conditional subtractions bring it back under m.
    always_comb begin
        mulSum   = {1'b0, acc_i[WIDTH-1:0]} + (lo_i[0] ? {1'b0, a_i} : '0);

        divShift = {acc_i[WIDTH-1:0], lo_i[WIDTH-1]};
        divFits  = (divShift >= {1'b0, b_i});
        divDiff  = divShift - {1'b0, b_i};

        modM     = {2'b00, m_i};
        modT     = (acc_i << 1) + (lo_i[WIDTH-1] ? {2'b00, a_i} : '0);
        modT1    = (modT  >= modM) ? (modT  - modM) : modT;
        modT2    = (modT1 >= modM) ? (modT1 - modM) : modT1;

        acc_o    = '0;
        lo_o     = lo_i;

        case (mode_i)
            OP_MUL: begin
                acc_o = {2'b00, mulSum[WIDTH:1]};
                lo_o  = {mulSum[0], lo_i[WIDTH-1:1]};
            end
            OP_DIV: begin
                acc_o = divFits ? {1'b0, divDiff} : {1'b0, divShift};
                lo_o  = {lo_i[WIDTH-2:0], divFits};
            end
            OP_MODMUL: begin
                acc_o = modT2;
                lo_o  = {lo_i[WIDTH-2:0], 1'b0};
            end
            default: begin
                acc_o = '0;
                lo_o  = lo_i;
            end
        endcase
    end

endmodule

// File: rtl/seq_arith_unit.sv
// ---------------------------------------------------------------------------
// seq_arith_unit
// Iterative multiply / divide / modular-multiply engine producing one result
// bit per clock, driven through a start/busy/done handshake.
// Ports:
//   clk    : clock, all state changes on the rising edge
//   rst    : synchronous active-high reset
//   start  : request, sampled only while busy is low
//   mode   : 00 MUL, 01 DIV, 10 MODMUL, 11 reserved (always rejected)
//   a      : operand A (multiplicand / dividend)
//   b      : operand B (multiplier / divisor)
//   m      : modulus, used by MODMUL only
//   busy   : high while an operation is iterating
//   done   : one-cycle pulse, results valid from this cycle
//   res_lo : MUL product low / DIV quotient / MODMUL (a*b) mod m
//   res_hi : MUL product high / DIV remainder / MODMUL zero
//   err    : request was rejected, valid with done
// ---------------------------------------------------------------------------
module seq_arith_unit
    import seq_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             err
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e           state_q;
    op_e              opMode_q;
    logic [WIDTH-1:0] opA_q;
    logic [WIDTH-1:0] opB_q;
    logic [WIDTH-1:0] opM_q;
    logic [WIDTH+1:0] acc_q;
    logic [WIDTH+1:0] acc_d;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] lo_d;
    logic [CNT_W-1:0] count_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [WIDTH-1:0] resLo_q;
    logic [WIDTH-1:0] resHi_q;
    op_e              reqMode;
    logic             illegalReq;

    assign reqMode = op_e'(mode);

    // Screen the incoming request before accepting it. A rejected request
    // skips the iteration entirely and reports err on the very next cycle;
    // checking a, b < m up front is what keeps the MODMUL accumulator below
    // 3m and makes two conditional subtractions per step sufficient.
    always_comb begin
        illegalReq = 1'b0;
        case (reqMode)
            OP_DIV:    illegalReq = (b == '0);
            OP_MODMUL: illegalReq = (m == '0) || (a >= m) || (b >= m);
            OP_RSVD:   illegalReq = 1'b1;
            default:   illegalReq = 1'b0;
        endcase
    end

    // One shared single-step datapath; the FSM below decides when its result
    // is written back into the working registers.
    seq_arith_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .mode_i (opMode_q),
        .acc_i  (acc_q),
        .lo_i   (lo_q),
        .a_i    (opA_q),
        .b_i    (opB_q),
        .m_i    (opM_q),
        .acc_o  (acc_d),
        .lo_o   (lo_d)
    );

    // Control FSM with registered handshake outputs.
    // IDLE and DONE behave identically towards a new request, which is what
    // lets a controller issue the next operation in the done cycle. On accept
    // the operands are captured, the visible results are cleared, and the
    // working registers are seeded: MUL shifts the multiplier out of the low
    // word LSB-first, DIV shifts the dividend out MSB-first, MODMUL scans the
    // multiplier MSB-first. The step counter starts at WIDTH-1 and the last
    // iteration runs while it reads zero, giving exactly WIDTH RUN cycles.
    // Results are copied out from the final step's outputs so they never show
    // intermediate values and simply hold until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            opMode_q <= OP_MUL;
            opA_q    <= '0;
            opB_q    <= '0;
            opM_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            resLo_q  <= '0;
            resHi_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    acc_q <= acc_d;
                    lo_q  <= lo_d;
                    if (count_q == '0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        if (opMode_q == OP_MODMUL) begin
                            resLo_q <= acc_d[WIDTH-1:0];
                            resHi_q <= '0;
                        end else begin
                            resLo_q <= lo_d;
                            resHi_q <= acc_d[WIDTH-1:0];
                        end
                    end else begin
                        count_q <= count_q - CNT_W'(1);
                    end
                end
                default: begin
                    if (start) begin
                        opMode_q <= reqMode;
                        opA_q    <= a;
                        opB_q    <= b;
                        opM_q    <= m;
                        acc_q    <= '0;
                        lo_q     <= (reqMode == OP_DIV) ? a : b;
                        count_q  <= CNT_W'(WIDTH - 1);
                        resLo_q  <= '0;
                        resHi_q  <= '0;
                        if (illegalReq) begin
                            state_q <= S_DONE;
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_RUN;
                            err_q   <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign res_lo = resLo_q;
    assign res_hi = resHi_q;

endmodule
